// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data_mem between the CPU (port 0)
// and the DMA/debug port (port 1). One-cycle BUSY per access, registered ack/rdata.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          word_we0,
  input  logic          word_we1,
  input  logic          byte_we0,
  input  logic          byte_we1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_word_we,
  output logic          mem_byte_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   grant_cnt
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [15:0]   grant_cnt_q;
  logic          eff_req0, eff_req1;

  always_comb begin
    // The port being served gets its ack at the close of this cycle, so it is
    // kept out of the grant decided now; it may win again from its ack cycle.
    eff_req0 = req0 & (state_q != StBusy0);
    eff_req1 = req1 & (state_q != StBusy1);

    state_d  = StIdle;
    rr_ptr_d = rr_ptr_q;
    if (eff_req0 && (!eff_req1 || !rr_ptr_q)) begin
      state_d  = StBusy0;
      rr_ptr_d = 1'b1;
    end else if (eff_req1) begin
      state_d  = StBusy1;
      rr_ptr_d = 1'b0;
    end

    mem_addr    = '0;
    mem_wdata   = '0;
    mem_word_we = 1'b0;
    mem_byte_we = 1'b0;
    unique case (state_q)
      StBusy0: begin
        mem_addr    = addr0;
        mem_wdata   = wdata0;
        mem_word_we = word_we0;
        mem_byte_we = byte_we0 & ~word_we0;
      end
      StBusy1: begin
        mem_addr    = addr1;
        mem_wdata   = wdata1;
        mem_word_we = word_we1;
        mem_byte_we = byte_we1 & ~word_we1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ack0_q   <= (state_q == StBusy0);
      ack1_q   <= (state_q == StBusy1);
      if (state_q == StBusy0) rdata0_q <= mem_rdata;
      if (state_q == StBusy1) rdata1_q <= mem_rdata;
      if ((state_q != StIdle) && (grant_cnt_q != 16'hFFFF)) begin
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign stall0    = req0 & ~ack0_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table with a read-data scoreboard,
// plus hand sequences for contention, ack masking and reset during a store.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        word_we0 = 1'b0, word_we1 = 1'b0, byte_we0 = 1'b0, byte_we1 = 1'b0;
  logic        ack0, ack1, stall0, mem_word_we, mem_byte_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] grant_cnt;
  logic        preload = 1'b0;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  int          exp_cnt;

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .word_we0(word_we0), .word_we1(word_we1), .byte_we0(byte_we0), .byte_we1(byte_we1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_word_we(mem_word_we),
    .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata), .grant_cnt(grant_cnt)
  );

  // data_mem model: combinational read, stores on the rising edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'hCAFEF00D;
      mem[12] <= 32'h01020304;
    end else if (mem_word_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end else if (mem_byte_we) begin
      mem[mem_addr[9:2]][mem_addr[1:0]*8 +: 8] <= mem_wdata[7:0];
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wwe;
    logic        bwe;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    preload = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    word_we0 = 1'b0; word_we1 = 1'b0; byte_we0 = 1'b0; byte_we1 = 1'b0;
    tick();
    tick();
    preload = 1'b0;
    chk("rst_ack0", {31'b0, ack0}, 32'h0);
    chk("rst_ack1", {31'b0, ack1}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_grant_cnt", {16'b0, grant_cnt}, 32'h0);
    chk("rst_mem_we", {30'b0, mem_word_we, mem_byte_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;
    exp_cnt = 0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    logic got;
    logic [31:0] exp_rd, act_rd, busy_addr;
    logic [1:0]  busy_we;
    if (v.port == 1'b0) begin
      addr0 = v.addr; wdata0 = v.wdata; word_we0 = v.wwe; byte_we0 = v.bwe; req0 = 1'b1;
      sb0.push_back(v.exp_rdata);
      #1;
      chk($sformatf("v%0d_stall_req", idx), {31'b0, stall0}, 32'h1);
    end else begin
      addr1 = v.addr; wdata1 = v.wdata; word_we1 = v.wwe; byte_we1 = v.bwe; req1 = 1'b1;
      sb1.push_back(v.exp_rdata);
    end
    got = 1'b0;
    lat = 0;
    busy_addr = '0;
    busy_we = '0;
    for (int c = 1; c <= 8 && !got; c++) begin
      tick();
      if (c == 1) begin
        busy_addr = mem_addr;
        busy_we   = {mem_word_we, mem_byte_we};
        if (v.port == 1'b0) chk($sformatf("v%0d_stall_busy", idx), {31'b0, stall0}, 32'h1);
      end
      if ((v.port == 1'b0) ? ack0 : ack1) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, 32'd2);
    chk($sformatf("v%0d_mem_addr", idx), busy_addr, v.addr);
    chk($sformatf("v%0d_mem_we", idx), {30'b0, busy_we}, {30'b0, v.wwe, v.bwe & ~v.wwe});
    exp_rd = (v.port == 1'b0) ? sb0.pop_front() : sb1.pop_front();
    act_rd = (v.port == 1'b0) ? rdata0 : rdata1;
    chk($sformatf("v%0d_rdata", idx), act_rd, exp_rd);
    if (v.port == 1'b0) begin
      chk($sformatf("v%0d_stall_ack", idx), {31'b0, stall0}, 32'h0);
      req0 = 1'b0; word_we0 = 1'b0; byte_we0 = 1'b0;
    end else begin
      req1 = 1'b0; word_we1 = 1'b0; byte_we1 = 1'b0;
    end
    exp_cnt++;
    tick();
    chk($sformatf("v%0d_mem_content", idx), mem[v.addr[9:2]], v.exp_mem);
    chk($sformatf("v%0d_rdata_hold", idx), (v.port == 1'b0) ? rdata0 : rdata1, exp_rd);
    chk($sformatf("v%0d_grant_cnt", idx), {16'b0, grant_cnt}, exp_cnt);
  endtask

  initial begin
    int n0, n1, nt, exp_port, n;
    logic saw;
    logic [31:0] e;

    vecs[0] = '{1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h30, 32'h0,        1'b0, 1'b0, 32'h01020304, 32'h01020304};
    vecs[2] = '{1'b1, 32'h20, 32'h11223344, 1'b1, 1'b1, 32'hCAFEF00D, 32'h11223344};
    vecs[3] = '{1'b0, 32'h31, 32'h000000AA, 1'b0, 1'b1, 32'h01020304, 32'h0102AA04};
    vecs[4] = '{1'b1, 32'h23, 32'h00000055, 1'b0, 1'b1, 32'h11223344, 32'h55223344};
    vecs[5] = '{1'b0, 32'h10, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678};
    vecs[6] = '{1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h12345678, 32'h12345678};
    vecs[7] = '{1'b1, 32'h24, 32'h0,        1'b0, 1'b0, 32'h00000000, 32'h00000000};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Simultaneous requests after reset: port 0 first, then port 1; twice to
    // confirm the pointer has returned to port 0.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      addr0 = 32'h10; addr1 = 32'h30; req0 = 1'b1; req1 = 1'b1;
      sb0.push_back(32'hDEADBEEF);
      sb1.push_back(32'h01020304);
      tick();
      tick();
      chk($sformatf("sim%0d_ack0", r), {30'b0, ack0, ack1}, 32'h2);
      e = sb0.pop_front();
      chk($sformatf("sim%0d_rdata0", r), rdata0, e);
      req0 = 1'b0;
      tick();
      chk($sformatf("sim%0d_ack1", r), {30'b0, ack0, ack1}, 32'h1);
      e = sb1.pop_front();
      chk($sformatf("sim%0d_rdata1", r), rdata1, e);
      req1 = 1'b0;
      tick();
    end

    // Continuous contention: four accesses per port, acks alternate every cycle.
    do_reset();
    addr0 = 32'h10; addr1 = 32'h30; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb0.push_back(32'hDEADBEEF);
      sb1.push_back(32'h01020304);
    end
    n0 = 0; n1 = 0; nt = 0; exp_port = 0;
    for (int c = 1; c <= 20 && (n0 < 4 || n1 < 4); c++) begin
      tick();
      if (ack0 && ack1) chk("cont_both_ack", 32'h1, 32'h0);
      if (ack0 || ack1) begin
        chk("cont_order", ack1 ? 32'd1 : 32'd0, exp_port);
        chk("cont_cycle", c, nt + 2);
        nt++;
        exp_port = ack1 ? 0 : 1;
      end
      if (ack0) begin
        e = sb0.pop_front();
        chk("cont_rdata0", rdata0, e);
        n0++;
        if (n0 == 4) req0 = 1'b0;
      end
      if (ack1) begin
        e = sb1.pop_front();
        chk("cont_rdata1", rdata1, e);
        n1++;
        if (n1 == 4) req1 = 1'b0;
      end
    end
    tick();
    chk("cont_total", nt, 32'd8);
    chk("cont_grant_cnt", {16'b0, grant_cnt}, 32'd8);

    // Ack masking: port 0 holds req through three accesses, acks every other cycle.
    addr0 = 32'h30; req0 = 1'b1;
    n = 0;
    for (int c = 1; c <= 12 && n < 3; c++) begin
      tick();
      if (ack0) begin
        chk("mask_ack_cycle", c, 2 * (n + 1));
        chk("mask_ack_mem_idle", mem_addr, 32'h0);
        chk("mask_rdata", rdata0, 32'h01020304);
        n++;
        if (n == 3) req0 = 1'b0;
      end
    end
    chk("mask_count", n, 32'd3);
    tick();
    chk("mask_grant_cnt", {16'b0, grant_cnt}, 32'd11);

    // Reset asserted in the middle of a BUSY1 word store.
    addr1 = 32'h24; wdata1 = 32'h99999999; word_we1 = 1'b1; req1 = 1'b1;
    tick();
    chk("rbusy_we_before", {31'b0, mem_word_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rbusy_we_drop", {31'b0, mem_word_we}, 32'h0);
    chk("rbusy_addr", mem_addr, 32'h0);
    chk("rbusy_ack1", {31'b0, ack1}, 32'h0);
    chk("rbusy_rdata0", rdata0, 32'h0);
    chk("rbusy_grant_cnt", {16'b0, grant_cnt}, 32'h0);
    req1 = 1'b0; word_we1 = 1'b0;
    tick();
    chk("rbusy_no_commit", mem[9], 32'h0);
    #2 reset = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack1) saw = 1'b1;
    end
    chk("rbusy_no_ack1", {31'b0, saw}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
